alu_exec_stage: RTL and testbench

Execute-stage ALU for the pipelined RISC-V core. Consumes the 4-bit ALU operation code produced by the ALU control decoder, plus the two operands from the register-read stage. Produces a registered result and a zero flag for the memory/writeback and branch logic. Single-cycle ops complete in one cycle; shifts run on an iterative 8-bit-per-step shifter. A valid/ready handshake lets the stage stall the pipeline during shifts.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_arith_core.sv | 26 ++
 rtl/alu_exec_stage.sv | 121 ++++++++++++
 tb/tb_alu_exec_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU control decoder.
// Op codes, default widths and FSM state encoding.
package alu_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned SHAMT_W            = 5;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_SRL = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } exec_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_arith_core.sv
// Combinational single-cycle ALU operations; shift and reserved codes yield zero.
module alu_arith_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            ALU_XOR: result = a ^ b;
            ALU_LUI: result = b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle ops via alu_arith_core, iterative shifter,
// registered result with valid/ready handshake and synchronous flush.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    exec_state_t           state_q;
    exec_state_t           state_d;
    logic                  accept;
    logic                  op_is_shift;
    logic [SHAMT_W-1:0]    shamt_in;
    logic [DATA_WIDTH-1:0] core_result;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [SHAMT_W-1:0]    rem_q;
    logic                  shift_left_q;
    logic [SHAMT_W-1:0]    step_amt;
    logic [DATA_WIDTH-1:0] shifted;

    alu_arith_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_arith (
        .op    (ALU_Operation_i),
        .a     (A_i),
        .b     (B_i),
        .result(core_result)
    );

    assign op_is_shift = is_shift_op(ALU_Operation_i);
    assign shamt_in    = B_i[SHAMT_W-1:0];
    assign accept      = valid_i && ready_o && !flush_i;

    // Distance applied this cycle is min(rem, SHIFT_STEP).
    assign step_amt = (rem_q > SHAMT_W'(SHIFT_STEP)) ? SHAMT_W'(SHIFT_STEP) : rem_q;
    assign shifted  = shift_left_q ? (shift_q << step_amt) : (shift_q >> step_amt);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE with an accept behaves exactly like IDLE.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_d = (op_is_shift && (shamt_in != '0)) ? ST_SHIFT : ST_DONE;
                    end else if ((state_q == ST_DONE) && ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (rem_q == step_amt) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        ready_o = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_i);
        valid_o = (state_q == ST_DONE);
        Zero_o  = valid_o && (ALU_Result_o == '0);
    end

    // Shift datapath and result register; flush leaves the result untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALU_Result_o <= '0;
            shift_q      <= '0;
            rem_q        <= '0;
            shift_left_q <= 1'b0;
        end else if (!flush_i) begin
            if (accept) begin
                if (op_is_shift) begin
                    shift_q      <= A_i;
                    rem_q        <= shamt_in;
                    shift_left_q <= (ALU_Operation_i == ALU_SLL);
                    if (shamt_in == '0) begin
                        ALU_Result_o <= A_i;
                    end
                end else begin
                    ALU_Result_o <= core_result;
                end
            end else if (state_q == ST_SHIFT) begin
                shift_q <= shifted;
                rem_q   <= rem_q - step_amt;
                if (rem_q == step_amt) begin
                    ALU_Result_o <= shifted;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed vectors push expected results,
// a negedge monitor pops and compares on every consumed output.
module tb_alu_exec_stage;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] ALU_Result_o;
    logic        Zero_o;

    typedef struct {
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   pop_log[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    alu_exec_stage #(
        .DATA_WIDTH(32),
        .SHIFT_STEP(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .ALU_Operation_i(ALU_Operation_i),
        .A_i            (A_i),
        .B_i            (B_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .ALU_Result_o   (ALU_Result_o),
        .Zero_o         (Zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, hold it until accepted, return the number of stalled cycles.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [31:0] exp, output int waits);
        exp_t e;
        if (push) begin
            e.res  = exp;
            e.zero = (exp == 32'd0);
            sb.push_back(e);
        end
        ALU_Operation_i = op;
        A_i             = a;
        B_i             = b;
        valid_i         = 1'b1;
        waits           = 0;
        @(negedge clk);
        while (!ready_o && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!ready_o) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: ready_o never rose for op %0d", op);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Count negedges until valid_o, also counting those with ready_o low.
    task automatic latency(output int lows, output int rdy_lows);
        lows     = 0;
        rdy_lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid_o) break;
            lows++;
            if (!ready_o) rdy_lows++;
        end
        if (!valid_o) begin
            tests++;
            fails++;
            $display("FAIL latency_timeout: valid_o never rose");
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid_o && ready_i) begin
            pop_log.push_back(cyc);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got 0x%08h expected no output", ALU_Result_o);
            end else begin
                e = sb.pop_front();
                check("result", ALU_Result_o, e.res);
                check("zero", 32'(Zero_o), 32'(e.zero));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w1, w2, w3, lows, rdy_lows;
        reset = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        ALU_Operation_i = 4'd0; A_i = '0; B_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_result", ALU_Result_o, 32'd0);
        check("rst_zero", 32'(Zero_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        reset = 1'b0;

        // ADD wrapping to zero
        send(4'd0, 32'h0000_0005, 32'hFFFF_FFFB, 1'b1, 32'h0, w);
        latency(lows, rdy_lows);
        check("add_latency", 32'(lows), 32'd0);
        align();

        // Back-to-back SUB, XOR, LUI
        pop_log.delete();
        send(4'd4, 32'd10, 32'd3, 1'b1, 32'd7, w1);
        send(4'd6, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1, 32'h0F0F_F0F0, w2);
        send(4'd7, 32'hDEAD_BEEF, 32'h1234_5000, 1'b1, 32'h1234_5000, w3);
        check("b2b_stalls", 32'(w1 + w2 + w3), 32'd0);
        repeat (2) @(negedge clk);
        check("b2b_pops", 32'(pop_log.size()), 32'd3);
        if (pop_log.size() == 3) begin
            check("b2b_gap1", 32'(pop_log[1] - pop_log[0]), 32'd1);
            check("b2b_gap2", 32'(pop_log[2] - pop_log[1]), 32'd1);
        end
        align();

        // Shifts: worst case, single step, exact step, two steps, zero amount
        send(4'd2, 32'h1, 32'd31, 1'b1, 32'h8000_0000, w);
        latency(lows, rdy_lows);
        check("sll31_lat", 32'(lows), 32'd4);
        check("sll31_rdy_low", 32'(rdy_lows), 32'd4);
        align();
        send(4'd3, 32'h8000_0000, 32'h24, 1'b1, 32'h0800_0000, w);
        latency(lows, rdy_lows);
        check("srl4_lat", 32'(lows), 32'd1);
        align();
        send(4'd2, 32'h3, 32'd8, 1'b1, 32'h0000_0300, w);
        latency(lows, rdy_lows);
        check("sll8_lat", 32'(lows), 32'd1);
        align();
        send(4'd3, 32'hFFFF_FFFF, 32'd9, 1'b1, 32'h007F_FFFF, w);
        latency(lows, rdy_lows);
        check("srl9_lat", 32'(lows), 32'd2);
        align();
        send(4'd2, 32'h0000_1234, 32'h20, 1'b1, 32'h0000_1234, w);
        latency(lows, rdy_lows);
        check("sll0_lat", 32'(lows), 32'd0);
        align();

        // Result held while downstream stalls, then new op accepted on release
        ready_i = 1'b0;
        send(4'd0, 32'd2, 32'd3, 1'b1, 32'd5, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_result", ALU_Result_o, 32'd5);
            check("hold_ready", 32'(ready_o), 32'd0);
        end
        align();
        ready_i = 1'b1;
        send(4'd1, 32'h0000_00F0, 32'h0000_0F00, 1'b1, 32'h0000_0FF0, w);
        check("release_stall", 32'(w), 32'd0);
        repeat (2) align();

        // Flush abandons an in-flight shift
        send(4'd2, 32'h1, 32'd20, 1'b0, 32'h0, w);
        flush_i = 1'b1;
        align();
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_ready", 32'(ready_o), 32'd1);
        repeat (5) @(negedge clk);
        check("flush_quiet", 32'(valid_o), 32'd0);
        align();

        // Asynchronous reset mid-shift
        send(4'd2, 32'h1, 32'd31, 1'b0, 32'h0, w);
        align();
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", 32'(valid_o), 32'd0);
        check("areset_result", ALU_Result_o, 32'd0);
        check("areset_zero", 32'(Zero_o), 32'd0);
        check("areset_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        align();

        // Reserved code, AND, SUB underflow
        send(4'hC, 32'd5, 32'd7, 1'b1, 32'h0, w);
        send(4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'h0F00_0F00, w);
        send(4'd4, 32'd3, 32'd10, 1'b1, 32'hFFFF_FFF9, w);
        repeat (3) align();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
